// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, writeback select codes,
// and the memory-stage FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [2:0]  fmux_t;

    // Writeback select encodings carried on final_mux.
    localparam fmux_t FMUX_ALU   = 3'd0;
    localparam fmux_t FMUX_LOAD  = 3'd1;
    localparam fmux_t FMUX_PC4   = 3'd2;
    localparam fmux_t FMUX_UTYPE = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HALTED
    } mem_state_t;

endpackage

// File: rtl/writeback_datapath_if.sv
// Bundle of MEM/WB register outputs consumed by the writeback stage.
interface writeback_datapath_if;
    import cpu_types_pkg::*;

    logic     valid;
    fmux_t    finalMux;
    word_t    dmemload;
    word_t    outPort;
    word_t    nextMemaddr;
    word_t    uType;
    logic     tempHalt;
    regbits_t wsel;
    logic     regwen;

    modport producer (
        output valid, finalMux, dmemload, outPort, nextMemaddr,
               uType, tempHalt, wsel, regwen
    );

    modport consumer (
        input  valid, finalMux, dmemload, outPort, nextMemaddr,
               uType, tempHalt, wsel, regwen
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank: data fields update only on load_i, and the
// register write enable is masked whenever the bank holds no new instruction.
module mem_wb_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        loadData_i,
    input  logic [2:0]  finalMux_i,
    input  logic [31:0] dmemload_i,
    input  logic [31:0] outPort_i,
    input  logic [31:0] nextMemaddr_i,
    input  logic [31:0] uType_i,
    input  logic        halt_i,
    input  logic [4:0]  wsel_i,
    input  logic        regwen_i,
    writeback_datapath_if.producer wb
);

    logic        valid_q;
    logic [2:0]  finalMux_q;
    logic [31:0] dmemload_q;
    logic [31:0] outPort_q;
    logic [31:0] nextMemaddr_q;
    logic [31:0] uType_q;
    logic        halt_q;
    logic [4:0]  wsel_q;
    logic        regwen_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            finalMux_q    <= '0;
            dmemload_q    <= '0;
            outPort_q     <= '0;
            nextMemaddr_q <= '0;
            uType_q       <= '0;
            halt_q        <= 1'b0;
            wsel_q        <= '0;
            regwen_q      <= 1'b0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                finalMux_q    <= finalMux_i;
                outPort_q     <= outPort_i;
                nextMemaddr_q <= nextMemaddr_i;
                uType_q       <= uType_i;
                halt_q        <= halt_i;
                wsel_q        <= wsel_i;
                regwen_q      <= regwen_i;
                // Stores and ALU ops leave the last load value in place.
                if (loadData_i) begin
                    dmemload_q <= dmemload_i;
                end
            end
        end
    end

    assign wb.valid       = valid_q;
    assign wb.finalMux    = finalMux_q;
    assign wb.dmemload    = dmemload_q;
    assign wb.outPort     = outPort_q;
    assign wb.nextMemaddr = nextMemaddr_q;
    assign wb.uType       = uType_q;
    assign wb.tempHalt    = halt_q;
    assign wb.wsel        = wsel_q;
    assign wb.regwen      = regwen_q & valid_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage: runs the dcache request handshake, stalls EX/MEM while an
// access is outstanding, and freezes after a halt until reset.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic                   ex_dmemREN,
    input  logic                   ex_dmemWEN,
    input  logic [31:0]            ex_addr,
    input  logic [31:0]            ex_store,
    input  logic [2:0]             ex_final_mux,
    input  logic [31:0]            ex_out_port,
    input  logic [31:0]            ex_next_memaddr,
    input  logic [31:0]            ex_u_type,
    input  logic                   ex_halt,
    input  logic [4:0]             ex_wsel,
    input  logic                   ex_regwen,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [31:0]            dmemaddr,
    output logic [31:0]            dmemstore,
    input  logic                   dhit,
    input  logic [31:0]            dmemload,
    output logic                   wb_valid,
    output logic [2:0]             final_mux,
    output logic [31:0]            wb_dmemload,
    output logic [31:0]            out_port,
    output logic [31:0]            next_memaddr,
    output logic [31:0]            u_type,
    output logic                   temp_halt,
    output logic [4:0]             wb_wsel,
    output logic                   wb_regwen,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    mem_state_t state_q, state_d;

    logic                   reqRen_q;
    logic                   reqWen_q;
    word_t                  addr_q;
    word_t                  store_q;
    fmux_t                  finalMux_q;
    word_t                  outPort_q;
    word_t                  nextMemaddr_q;
    word_t                  uType_q;
    regbits_t               wsel_q;
    logic                   regwen_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic transfer;
    logic isMemOp;
    logic latchReq;
    logic clearReq;
    logic wbLoad;
    logic fromLatch;
    logic captureLoad;
    logic wbHalt;

    assign ex_ready = (state_q == IDLE);
    assign transfer = ex_valid & ex_ready;
    assign isMemOp  = ex_dmemREN | ex_dmemWEN;

    // Halt takes priority over any memory op on the same instruction.
    always_comb begin
        state_d     = state_q;
        latchReq    = 1'b0;
        clearReq    = 1'b0;
        wbLoad      = 1'b0;
        fromLatch   = 1'b0;
        captureLoad = 1'b0;
        wbHalt      = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (ex_halt) begin
                        wbLoad  = 1'b1;
                        wbHalt  = 1'b1;
                        state_d = HALTED;
                    end else if (isMemOp) begin
                        latchReq = 1'b1;
                        state_d  = ACCESS;
                    end else begin
                        wbLoad = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (dhit) begin
                    wbLoad      = 1'b1;
                    fromLatch   = 1'b1;
                    captureLoad = reqRen_q;
                    clearReq    = 1'b1;
                    state_d     = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A request with both enables set is issued as a store only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            reqRen_q      <= 1'b0;
            reqWen_q      <= 1'b0;
            addr_q        <= '0;
            store_q       <= '0;
            finalMux_q    <= '0;
            outPort_q     <= '0;
            nextMemaddr_q <= '0;
            uType_q       <= '0;
            wsel_q        <= '0;
            regwen_q      <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q <= state_d;
            if (latchReq) begin
                reqRen_q      <= ex_dmemREN & ~ex_dmemWEN;
                reqWen_q      <= ex_dmemWEN;
                addr_q        <= ex_addr;
                store_q       <= ex_store;
                finalMux_q    <= ex_final_mux;
                outPort_q     <= ex_out_port;
                nextMemaddr_q <= ex_next_memaddr;
                uType_q       <= ex_u_type;
                wsel_q        <= ex_wsel;
                regwen_q      <= ex_regwen;
            end else if (clearReq) begin
                reqRen_q <= 1'b0;
                reqWen_q <= 1'b0;
            end
            if (state_q == ACCESS && stall_q != {STALL_CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign dmemREN      = reqRen_q;
    assign dmemWEN      = reqWen_q;
    assign dmemaddr     = addr_q;
    assign dmemstore    = store_q;
    assign stall_cycles = stall_q;

    writeback_datapath_if wbIf ();

    mem_wb_reg u_mem_wb_reg (
        .clk_i         (CLK),
        .rst_i         (RST),
        .load_i        (wbLoad),
        .loadData_i    (captureLoad),
        .finalMux_i    (fromLatch ? finalMux_q    : ex_final_mux),
        .dmemload_i    (dmemload),
        .outPort_i     (fromLatch ? outPort_q     : ex_out_port),
        .nextMemaddr_i (fromLatch ? nextMemaddr_q : ex_next_memaddr),
        .uType_i       (fromLatch ? uType_q       : ex_u_type),
        .halt_i        (wbHalt),
        .wsel_i        (fromLatch ? wsel_q        : ex_wsel),
        .regwen_i      (fromLatch ? regwen_q      : ex_regwen),
        .wb            (wbIf)
    );

    assign wb_valid     = wbIf.valid;
    assign final_mux    = wbIf.finalMux;
    assign wb_dmemload  = wbIf.dmemload;
    assign out_port     = wbIf.outPort;
    assign next_memaddr = wbIf.nextMemaddr;
    assign u_type       = wbIf.uType;
    assign temp_halt    = wbIf.tempHalt;
    assign wb_wsel      = wbIf.wsel;
    assign wb_regwen    = wbIf.regwen;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU, load, store, halt, reset-mid-access
// and back-to-back sequences with hand-computed expectations.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_dmemREN;
    logic        ex_dmemWEN;
    logic [31:0] ex_addr;
    logic [31:0] ex_store;
    logic [2:0]  ex_final_mux;
    logic [31:0] ex_out_port;
    logic [31:0] ex_next_memaddr;
    logic [31:0] ex_u_type;
    logic        ex_halt;
    logic [4:0]  ex_wsel;
    logic        ex_regwen;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        wb_valid;
    logic [2:0]  final_mux;
    logic [31:0] wb_dmemload;
    logic [31:0] out_port;
    logic [31:0] next_memaddr;
    logic [31:0] u_type;
    logic        temp_halt;
    logic [4:0]  wb_wsel;
    logic        wb_regwen;
    logic [31:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage #(.STALL_CNT_W(32)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_dmemREN      (ex_dmemREN),
        .ex_dmemWEN      (ex_dmemWEN),
        .ex_addr         (ex_addr),
        .ex_store        (ex_store),
        .ex_final_mux    (ex_final_mux),
        .ex_out_port     (ex_out_port),
        .ex_next_memaddr (ex_next_memaddr),
        .ex_u_type       (ex_u_type),
        .ex_halt         (ex_halt),
        .ex_wsel         (ex_wsel),
        .ex_regwen       (ex_regwen),
        .dmemREN         (dmemREN),
        .dmemWEN         (dmemWEN),
        .dmemaddr        (dmemaddr),
        .dmemstore       (dmemstore),
        .dhit            (dhit),
        .dmemload        (dmemload),
        .wb_valid        (wb_valid),
        .final_mux       (final_mux),
        .wb_dmemload     (wb_dmemload),
        .out_port        (out_port),
        .next_memaddr    (next_memaddr),
        .u_type          (u_type),
        .temp_halt       (temp_halt),
        .wb_wsel         (wb_wsel),
        .wb_regwen       (wb_regwen),
        .stall_cycles    (stall_cycles)
    );

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic valid, input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] store,
                                 input logic [2:0] fmux, input logic [31:0] outp,
                                 input logic [4:0] wsel, input logic regwen,
                                 input logic halt);
        ex_valid        = valid;
        ex_dmemREN      = ren;
        ex_dmemWEN      = wen;
        ex_addr         = addr;
        ex_store        = store;
        ex_final_mux    = fmux;
        ex_out_port     = outp;
        ex_next_memaddr = outp + 32'd4;
        ex_u_type       = 32'h0001_0000;
        ex_wsel         = wsel;
        ex_regwen       = regwen;
        ex_halt         = halt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        RST      = 1'b1;
        dhit     = 1'b0;
        dmemload = 32'h0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        tick();
        RST = 1'b0;
        tick();

        // Reset state
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_regwen", {31'b0, wb_regwen}, 32'd0);
        checkOutput("rst_out_port", out_port, 32'd0);
        checkOutput("rst_temp_halt", {31'b0, temp_halt}, 32'd0);
        checkOutput("rst_stall", stall_cycles, 32'd0);
        checkOutput("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        checkOutput("rst_dmemREN", {31'b0, dmemREN}, 32'd0);

        // ALU op, one-cycle latency
        applyStimulus(1, 0, 0, 0, 0, 3'd0, 32'h10, 5'd3, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("alu_out_port", out_port, 32'h10);
        checkOutput("alu_next_memaddr", next_memaddr, 32'h14);
        checkOutput("alu_wsel", {27'b0, wb_wsel}, 32'd3);
        checkOutput("alu_regwen", {31'b0, wb_regwen}, 32'd1);
        checkOutput("alu_ex_ready", {31'b0, ex_ready}, 32'd1);

        // Load to 0x100, dhit in the third ACCESS cycle
        applyStimulus(1, 1, 0, 32'h100, 0, 3'd1, 32'h100, 5'd5, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 32'hFFFF, 0, 0, 32'hFFFF, 0, 0, 0);
        checkOutput("ld_bubble_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("ld_bubble_regwen", {31'b0, wb_regwen}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checkOutput($sformatf("ld_ren_c%0d", c), {31'b0, dmemREN}, 32'd1);
            checkOutput($sformatf("ld_addr_c%0d", c), dmemaddr, 32'h100);
            checkOutput($sformatf("ld_ready_c%0d", c), {31'b0, ex_ready}, 32'd0);
        end
        dhit     = 1'b1;
        dmemload = 32'hDEAD_BEEF;
        tick();
        dhit     = 1'b0;
        dmemload = 32'h0;
        checkOutput("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("ld_dmemload", wb_dmemload, 32'hDEAD_BEEF);
        checkOutput("ld_stall", stall_cycles, 32'd3);
        checkOutput("ld_ren_done", {31'b0, dmemREN}, 32'd0);
        checkOutput("ld_out_port", out_port, 32'h100);
        checkOutput("ld_final_mux", {29'b0, final_mux}, 32'd1);
        checkOutput("ld_wsel", {27'b0, wb_wsel}, 32'd5);
        checkOutput("ld_ready_done", {31'b0, ex_ready}, 32'd1);

        // Store with both enables set: store only, dhit in first cycle
        applyStimulus(1, 1, 1, 32'h200, 32'h1234_5678, 3'd0, 32'h200, 5'd0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("st_wen", {31'b0, dmemWEN}, 32'd1);
        checkOutput("st_ren", {31'b0, dmemREN}, 32'd0);
        checkOutput("st_data", dmemstore, 32'h1234_5678);
        checkOutput("st_addr", dmemaddr, 32'h200);
        checkOutput("st_bubble_valid", {31'b0, wb_valid}, 32'd0);
        dhit     = 1'b1;
        dmemload = 32'h5555_5555;
        tick();
        dhit     = 1'b0;
        checkOutput("st_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("st_dmemload_kept", wb_dmemload, 32'hDEAD_BEEF);
        checkOutput("st_wen_done", {31'b0, dmemWEN}, 32'd0);
        checkOutput("st_stall", stall_cycles, 32'd4);
        checkOutput("st_regwen", {31'b0, wb_regwen}, 32'd0);
        tick();
        checkOutput("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("idle_dmemload_hold", wb_dmemload, 32'hDEAD_BEEF);

        // Reset during an outstanding load
        applyStimulus(1, 1, 0, 32'h300, 0, 3'd1, 32'h300, 5'd7, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rsta_ren", {31'b0, dmemREN}, 32'd1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("rsta_ren_drop", {31'b0, dmemREN}, 32'd0);
        checkOutput("rsta_addr", dmemaddr, 32'd0);
        checkOutput("rsta_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rsta_out_port", out_port, 32'd0);
        checkOutput("rsta_dmemload", wb_dmemload, 32'd0);
        checkOutput("rsta_stall", stall_cycles, 32'd0);
        checkOutput("rsta_ready", {31'b0, ex_ready}, 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 3'd0, 32'h77, 5'd9, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rsta_alu_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("rsta_alu_out", out_port, 32'h77);

        // Back-to-back ALU ops
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 3'd0, 32'hA1 + k, 5'd2, 1, 0);
            tick();
            checkOutput($sformatf("b2b_valid_%0d", k), {31'b0, wb_valid}, 32'd1);
            checkOutput($sformatf("b2b_out_%0d", k), out_port, 32'hA1 + k);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("b2b_end_valid", {31'b0, wb_valid}, 32'd0);

        // Halt carrying a load request: halt wins, stage freezes
        applyStimulus(1, 1, 0, 32'h400, 0, 3'd0, 32'h99, 5'd1, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 3'd0, 32'h55, 5'd4, 1, 0);
        checkOutput("halt_temp", {31'b0, temp_halt}, 32'd1);
        checkOutput("halt_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("halt_ren", {31'b0, dmemREN}, 32'd0);
        checkOutput("halt_ready", {31'b0, ex_ready}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            dhit     = (c == 3);
            dmemload = 32'h1111_1111;
            tick();
            checkOutput($sformatf("hold_ready_%0d", c), {31'b0, ex_ready}, 32'd0);
            checkOutput($sformatf("hold_temp_%0d", c), {31'b0, temp_halt}, 32'd1);
            checkOutput($sformatf("hold_valid_%0d", c), {31'b0, wb_valid}, 32'd0);
            checkOutput($sformatf("hold_ren_%0d", c), {31'b0, dmemREN}, 32'd0);
        end
        dhit = 1'b0;
        checkOutput("hold_out_port", out_port, 32'h99);
        checkOutput("hold_dmemload", wb_dmemload, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
